mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and select sequencer for the shared 4:1 UDP multiplexer. Four requesters compete for the mux output; the block grants one at a time, drives the mux select pair `s1`/`s0` with the binary index of the winner, and holds the grant until the owner releases it. It sits directly in front of the mux instance, and its select outputs connect one-to-one to the mux select inputs.

---
 rtl/mux4_arb_pkg.sv | 24 ++
 rtl/rr_pick4.sv | 39 +++
 rtl/mux4_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// ----------------------------------------------------------------------------
// mux4_arb_pkg
// Shared definitions for the 4:1 mux round-robin arbiter and its helpers.
//   arb_state_e   : arbiter FSM states (IDLE, GRANT, TURN)
//   NUM_REQ       : number of requesters (mux inputs)
//   IDX_W         : width of a requester index / mux select pair
//   idx_to_onehot : index -> one-hot grant vector
// ----------------------------------------------------------------------------
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// ----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker for four requesters. The search starts
// at last+1 and wraps modulo 4, so the previous winner has lowest priority.
// Ports:
//   req  in  [NUM_REQ-1:0]  request vector
//   last in  [IDX_W-1:0]    index of the previous winner
//   win  out [IDX_W-1:0]    index of the winning requester (valid when any=1)
//   any  out                at least one request is present
// ----------------------------------------------------------------------------
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   win,
    output logic               any
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        // Offsets 1..4; the 2-bit add wraps, and offset 4 revisits last itself.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last + IDX_W'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter and select sequencer for a shared 4:1 mux. Grants one
// requester at a time, drives {s1,s0} with the owner's index and holds the
// grant until the owner pulses done or drops its request. Every release is
// followed by one dead TURN cycle and one IDLE arbitration cycle.
//
// Optional feature (macro MUX4_ARB_TIMEOUT_EN): an 8-bit hold counter forces
// release after MAX_HOLD grant cycles and pulses timeout for one cycle.
// Without the macro no counter is built and timeout is tied low.
//
// Ports:
//   clk     in        rising-edge clock
//   rst_n   in        synchronous active-low reset
//   req     in  [3:0] request vector, bit k = requester k (mux input ik)
//   done    in  [3:0] one-cycle release strobe from the current owner
//   grant   out [3:0] registered one-hot grant
//   s0      out       registered mux select LSB
//   s1      out       registered mux select MSB
//   busy    out       high while a grant is active
//   timeout out       one-cycle pulse on a forced release
// ----------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic               s0,
    output logic               s1,
    output logic               busy,
    output logic               timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   win;
    logic               any;
    logic               own_rel;
    logic               forced;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    // last_q always holds the current owner's index while in GRANT.
    assign own_rel = done[last_q] | ~req[last_q];

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    // A normal release in the same cycle takes precedence: no forced release.
    assign forced = (state_q == GRANT) && (hold_q == HOLD_LAST) && !own_rel;

    always_comb begin
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == IDLE && any) begin
            hold_d = '0;
        end else if (state_q == GRANT) begin
            if (forced) begin
                timeout_d = 1'b1;
            end else if (!own_rel) begin
                hold_d = hold_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign forced  = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any) state_d = GRANT;
            GRANT:   if (own_rel || forced) state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; selects only move on a new grant so the mux never glitches
    // through TURN/IDLE.
    always_comb begin
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        busy_d  = busy_q;
        if (state_q == IDLE && any) begin
            grant_d = idx_to_onehot(win);
            sel_d   = win;
            last_d  = win;
            busy_d  = 1'b1;
        end else if (state_q == GRANT && (own_rel || forced)) begin
            grant_d = '0;
            busy_d  = 1'b0;
        end
    end

    // last resets to 3 so requester 0 has first priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign s0    = sel_q[0];
    assign s1    = sel_q[1];
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Self-checking bench for mux4_rr_arbiter: directed scenarios followed by a
// randomized run, compared every cycle against a behavioural model that
// tracks owner, priority pointer and dead-cycle gap as plain integers.
// Honours MUX4_ARB_TIMEOUT_EN the same way as the design (MAX_HOLD = 4).
// ----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef MUX4_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       s0, s1, busy, timeout;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .s0      (s0),
        .s1      (s1),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner = -1 when nobody holds the mux.
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_gap   = 0;   // dead cycles still to wait before arbitration
    int m_held  = 0;   // completed grant cycles of current owner
    bit m_to    = 1'b0;

    // Grant-start log taken from the DUT output, for order/gap checks.
    int g_idx[$];
    int g_cyc[$];
    int cyc      = 0;
    int to_count = 0;
    logic [3:0] prev_g = 4'b0000;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rn, input logic [3:0] r, input logic [3:0] d);
        bit found;
        int w;
        m_to = 1'b0;
        if (!rn) begin
            m_owner = -1; m_last = 3; m_sel = 0; m_gap = 0; m_held = 0;
        end else if (m_owner >= 0) begin
            if (d[m_owner] || !r[m_owner]) begin
                m_owner = -1; m_gap = 1;
            end else if (TO_EN && m_held == MAX_HOLD - 1) begin
                m_owner = -1; m_gap = 1; m_to = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (r != 4'b0000) begin
            found = 1'b0;
            w = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && r[(m_last + k) % 4]) begin
                    w = (m_last + k) % 4;
                    found = 1'b1;
                end
            end
            m_owner = w; m_last = w; m_sel = w; m_held = 0;
        end
    endtask

    task automatic tick();
        logic [3:0] exp_g;
        @(posedge clk);
        model_step(rst_n, req, done);
        #1;
        cyc++;
        exp_g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        chk("grant",   {4'b0, grant},   {4'b0, exp_g});
        chk("sel",     {6'b0, s1, s0},  8'(m_sel));
        chk("busy",    {7'b0, busy},    {7'b0, (m_owner >= 0)});
        chk("timeout", {7'b0, timeout}, {7'b0, m_to});
        if (timeout) to_count++;
        if (grant != 4'b0000 && prev_g == 4'b0000) begin
            for (int k = 0; k < 4; k++)
                if (grant[k]) g_idx.push_back(k);
            g_cyc.push_back(cyc);
        end
        prev_g = grant;
    endtask

    // Owner pulses done in its H-th grant cycle, so each grant lasts H cycles.
    task automatic run_hold(input int n, input int h);
        for (int i = 0; i < n; i++) begin
            done = (m_owner >= 0 && m_held == h - 1) ? (4'b0001 << m_owner) : 4'b0000;
            tick();
        end
        done = 4'b0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0000; done = 4'b0000;
        tick();
        rst_n = 1'b1;
        g_idx.delete(); g_cyc.delete(); to_count = 0;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; done = 4'b0000;
        tick();
        tick();
        chk("rst_grant", {4'b0, grant}, 8'h00);
        chk("rst_sel",   {6'b0, s1, s0}, 8'h00);
        chk("rst_busy",  {7'b0, busy}, 8'h00);
        chk("rst_to",    {7'b0, timeout}, 8'h00);
        rst_n = 1'b1;

        // Single requester: grant, release on done, TURN holds select.
        req = 4'b0001;
        tick();
        chk("t1_grant", {4'b0, grant}, 8'h01);
        chk("t1_busy",  {7'b0, busy}, 8'h01);
        done = 4'b0001;
        tick();
        chk("t1_rel", {4'b0, grant}, 8'h00);
        done = 4'b0000; req = 4'b0000;
        tick();
        chk("t1_turn_sel", {6'b0, s1, s0}, 8'h00);
        tick();

        // All requesting, hold 3 cycles each: order 0,1,2,3,0 every 5 cycles.
        do_reset();
        req = 4'b1111;
        run_hold(24, 3);
        chk("t2_count", 8'(g_idx.size() >= 5), 8'h01);
        if (g_idx.size() >= 5) begin
            chk("t2_ord0", 8'(g_idx[0]), 8'd0);
            chk("t2_ord1", 8'(g_idx[1]), 8'd1);
            chk("t2_ord2", 8'(g_idx[2]), 8'd2);
            chk("t2_ord3", 8'(g_idx[3]), 8'd3);
            chk("t2_ord4", 8'(g_idx[4]), 8'd0);
            for (int i = 1; i < 5; i++)
                chk("t2_period", 8'(g_cyc[i] - g_cyc[i-1]), 8'd5);
        end

        // Wrap-around: set last=2, then 1011 -> 3, 0, 1.
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        tick();
        g_idx.delete(); g_cyc.delete();
        req = 4'b1011;
        run_hold(16, 2);
        chk("t3_count", 8'(g_idx.size() >= 3), 8'h01);
        if (g_idx.size() >= 3) begin
            chk("t3_ord0", 8'(g_idx[0]), 8'd3);
            chk("t3_ord1", 8'(g_idx[1]), 8'd0);
            chk("t3_ord2", 8'(g_idx[2]), 8'd1);
        end
        req = 4'b0000;
        run_hold(3, 1);

        // Non-owner done ignored; req drop releases.
        do_reset();
        req = 4'b0010;
        tick();
        done = 4'b0100;
        tick();
        chk("t4_ignore", {4'b0, grant}, 8'h02);
        done = 4'b0000;
        tick();
        req = 4'b0000;
        tick();
        chk("t4_drop", {4'b0, grant}, 8'h00);
        tick();
        tick();

        // Owner never releases.
        do_reset();
        if (TO_EN) begin
            req = 4'b0011;
            for (int i = 0; i < 8; i++) tick();
            chk("t5_to_pulses", 8'(to_count), 8'd1);
            chk("t5_count", 8'(g_idx.size() >= 2), 8'h01);
            if (g_idx.size() >= 2) begin
                chk("t5_first", 8'(g_idx[0]), 8'd0);
                chk("t5_next",  8'(g_idx[1]), 8'd1);
                chk("t5_gap",   8'(g_cyc[1] - g_cyc[0]), 8'd6);
            end
        end else begin
            req = 4'b0001;
            for (int i = 0; i < 120; i++) tick();
            chk("t5_held",  {4'b0, grant}, 8'h01);
            chk("t5_no_to", 8'(to_count), 8'd0);
        end
        req = 4'b0000;
        run_hold(4, 1);

        // Reset mid-grant: outputs back to reset, arbitration restarts at 0.
        req = 4'b0100;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("t6_grant", {4'b0, grant}, 8'h00);
        chk("t6_sel",   {6'b0, s1, s0}, 8'h00);
        chk("t6_busy",  {7'b0, busy}, 8'h00);
        chk("t6_to",    {7'b0, timeout}, 8'h00);
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        chk("t6_restart", {4'b0, grant}, 8'h01);
        req = 4'b0000;
        run_hold(4, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
